// File: rtl/program_counter.sv
// Fetch-address register plus IF-stage run control (IDLE/ARMED/RUN/HALT).
// Latency: pc and state update on the rising edge after inputs are sampled (1 cycle).
// Backpressure: stall holds pc, redirect overrides stall; fetchValid = running & ~stall.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   programLoaded           level: instruction memory holds a valid image
//   programStart            level: fetching starts on its rising edge while ARMED
//   incrPC                  sequential next PC from the external increment adder
//   redirect, redirectPC    branch/jump redirect and its target
//   stall, halt             hazard hold, halt decoded
//   pc                      current fetch address (adder input and I-memory address)
//   fetchValid              pc is a real fetch this cycle
//   running, halted         state is RUN / state is HALT
//   fetchCount              PC advances since leaving ARMED (wraps modulo 2^32)
//   pcFault                 sticky bounds/alignment violation
//
// Optional feature macro: PC_BOUNDS_CHECK_EN. When defined, a next PC above
// PROG_LIMIT or not word aligned is not loaded; the block halts and sets
// pcFault. When undefined, no check is made, pcFault stays 0 and pc wraps.
module program_counter #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PROG_LIMIT   = 32'h0000_0FFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        programLoaded,
    input  logic        programStart,
    input  logic [31:0] incrPC,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    input  logic        stall,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        fetchValid,
    output logic        running,
    output logic        halted,
    output logic [31:0] fetchCount,
    output logic        pcFault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    // A fetch limit that is not word aligned would make the last legal
    // fetch address unreachable by any aligned PC; reject it at elaboration.
    if (PROG_LIMIT[1:0] != 2'b00) begin : g_limit_align
        $error("PROG_LIMIT must be word aligned");
    end

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        start_q;
    logic [31:0] pc_nxt;
    logic [31:0] count_nxt;
    logic        fault_nxt;
    logic [31:0] target;
    logic        advance;
    logic        target_bad;
    logic        start_rise;

    // Redirect beats stall; otherwise the adder output is the candidate.
    assign target     = redirect ? redirectPC : incrPC;
    assign advance    = redirect | ~stall;
    // start_q samples programStart every cycle, so a level already high
    // when ARMED is entered is never seen as an edge.
    assign start_rise = programStart & ~start_q;

`ifdef PC_BOUNDS_CHECK_EN
    assign target_bad = (target > PROG_LIMIT) | (target[1:0] != 2'b00);
`else
    assign target_bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        count_nxt = fetchCount;
        fault_nxt = pcFault;

        // Losing the program image overrides every RUN action.
        if ((state != S_IDLE) && !programLoaded) begin
            state_nxt = S_IDLE;
            pc_nxt    = RESET_VECTOR;
            count_nxt = 32'd0;
            fault_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    pc_nxt    = RESET_VECTOR;
                    count_nxt = 32'd0;
                    fault_nxt = 1'b0;
                    if (programLoaded) begin
                        state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (start_rise) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        state_nxt = S_HALT;
                    end else if (advance) begin
                        if (target_bad) begin
                            // Park instead of loading an illegal address.
                            state_nxt = S_HALT;
                            fault_nxt = 1'b1;
                        end else begin
                            pc_nxt    = target;
                            count_nxt = fetchCount + 32'd1;
                        end
                    end
                end
                default: begin
                    // HALT: everything frozen until programLoaded drops.
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_VECTOR;
            fetchCount <= 32'd0;
            pcFault    <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            fetchCount <= count_nxt;
            pcFault    <= fault_nxt;
            start_q    <= programStart;
        end
    end

    assign running    = (state == S_RUN);
    assign halted     = (state == S_HALT);
    assign fetchValid = running & ~stall;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboarded bench for program_counter: a driver issues one input vector per
// cycle and pushes the expected post-edge outputs from a behavioural model; a
// monitor pops and compares one entry per cycle, #1 after the rising edge.
module tb_program_counter;

    logic        clk;
    logic        rst_n;
    logic        programLoaded;
    logic        programStart;
    logic [31:0] incrPC;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        stall;
    logic        halt;
    logic [31:0] pc;
    logic        fetchValid;
    logic        running;
    logic        halted;
    logic [31:0] fetchCount;
    logic        pcFault;

    program_counter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .programLoaded(programLoaded),
        .programStart (programStart),
        .incrPC       (incrPC),
        .redirect     (redirect),
        .redirectPC   (redirectPC),
        .stall        (stall),
        .halt         (halt),
        .pc           (pc),
        .fetchValid   (fetchValid),
        .running      (running),
        .halted       (halted),
        .fetchCount   (fetchCount),
        .pcFault      (pcFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        run;
        logic        hlt;
        logic        fv;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: run-control described by name, plain arithmetic for the PC.
    string       m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_flt;
    logic        m_prev;
    logic        ps_lvl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = "IDLE";
        m_pc   = 32'h0;
        m_cnt  = 32'h0;
        m_flt  = 1'b0;
        m_prev = 1'b0;
    endtask

    function automatic logic illegal(input logic [31:0] a);
`ifdef PC_BOUNDS_CHECK_EN
        return (a > 32'h0000_0FFC) || ((a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic step(input logic pl, input logic ps, input logic [31:0] incr,
                        input logic rd, input logic [31:0] rpc,
                        input logic st, input logic hl);
        exp_t        e;
        logic        rise;
        logic [31:0] nxt;
        @(posedge clk);
        #2;
        programLoaded = pl;
        programStart  = ps;
        incrPC        = incr;
        redirect      = rd;
        redirectPC    = rpc;
        stall         = st;
        halt          = hl;
        ps_lvl        = ps;

        rise   = ps && !m_prev;
        m_prev = ps;
        if (m_mode != "IDLE" && !pl) begin
            m_mode = "IDLE";
            m_pc   = 32'h0;
            m_cnt  = 32'h0;
            m_flt  = 1'b0;
        end else if (m_mode == "IDLE") begin
            m_pc  = 32'h0;
            m_cnt = 32'h0;
            m_flt = 1'b0;
            if (pl) m_mode = "ARMED";
        end else if (m_mode == "ARMED") begin
            if (rise) m_mode = "RUN";
        end else if (m_mode == "RUN") begin
            if (hl) begin
                m_mode = "HALT";
            end else if (rd || !st) begin
                nxt = rd ? rpc : incr;
                if (illegal(nxt)) begin
                    m_mode = "HALT";
                    m_flt  = 1'b1;
                end else begin
                    m_pc  = nxt;
                    m_cnt = m_cnt + 1;
                end
            end
        end

        e.pc  = m_pc;
        e.cnt = m_cnt;
        e.run = (m_mode == "RUN");
        e.hlt = (m_mode == "HALT");
        e.fv  = (m_mode == "RUN") && !st;
        e.flt = m_flt;
        exp_q.push_back(e);
    endtask

    // Sequential fetch with the adder's pc+4, no redirect/stall/halt.
    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b1, ps_lvl, m_pc + 32'd4, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Let the monitor consume the last expectation, leaving us mid-cycle.
    task automatic drain();
        @(posedge clk);
        #4;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"},         pc,         32'h0);
        chk({tag, "_running"},    {31'b0, running},    32'h0);
        chk({tag, "_halted"},     {31'b0, halted},     32'h0);
        chk({tag, "_fetchValid"}, {31'b0, fetchValid}, 32'h0);
        chk({tag, "_fetchCount"}, fetchCount, 32'h0);
        chk({tag, "_pcFault"},    {31'b0, pcFault},    32'h0);
    endtask

    // Monitor: compares one queued expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc",         pc,                  e.pc);
                chk("fetchCount", fetchCount,          e.cnt);
                chk("running",    {31'b0, running},    {31'b0, e.run});
                chk("halted",     {31'b0, halted},     {31'b0, e.hlt});
                chk("fetchValid", {31'b0, fetchValid}, {31'b0, e.fv});
                chk("pcFault",    {31'b0, pcFault},    {31'b0, e.flt});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        programLoaded = 1'b0;
        programStart  = 1'b0;
        incrPC        = 32'h0;
        redirect      = 1'b0;
        redirectPC    = 32'h0;
        stall         = 1'b0;
        halt          = 1'b0;
        ps_lvl        = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // programStart high before the image is loaded: no edge until it re-rises.
        step(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        // pc 4, 8, 12, 0x10
        seq(4);
        // redirect together with stall: redirect wins
        step(1'b1, 1'b1, m_pc + 32'd4, 1'b1, 32'h40, 1'b1, 1'b0);
        // stall only: pc held, fetchValid low
        step(1'b1, 1'b1, m_pc + 32'd4, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b1, m_pc + 32'd4, 1'b1, 32'h20, 1'b0, 1'b0);
        // halt at 0x20, stays frozen even with redirect requested
        step(1'b1, 1'b1, m_pc + 32'd4, 1'b0, 32'h0, 1'b0, 1'b1);
        seq(2);
        step(1'b1, 1'b1, m_pc + 32'd4, 1'b1, 32'h80, 1'b0, 1'b0);
        // drop programLoaded: back to IDLE at the reset vector
        step(1'b0, 1'b1, m_pc + 32'd4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, m_pc + 32'd4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, m_pc + 32'd4, 1'b0, 32'h0, 1'b0, 1'b0);
        seq(1);
        // out-of-range and misaligned redirects
        step(1'b1, 1'b1, m_pc + 32'd4, 1'b1, 32'h1000, 1'b0, 1'b0);
        step(1'b1, 1'b1, m_pc + 32'd4, 1'b1, 32'h102, 1'b0, 1'b0);
        seq(2);
        // re-arm, run a few cycles, then reset asynchronously mid-cycle
        step(1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        seq(3);
        drain();
        chk("running_before_async_reset", {31'b0, running}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            logic        pl;
            logic        ps;
            logic [31:0] incr;
            logic [31:0] rpc;
            pl   = ($urandom_range(0, 39) != 0);
            ps   = ($urandom_range(0, 3) == 0) ? ~ps_lvl : ps_lvl;
            incr = ($urandom_range(0, 9) == 0) ? $urandom : m_pc + 32'd4;
            if ($urandom_range(0, 7) == 0) rpc = $urandom;
            else                           rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            step(pl, ps, incr, ($urandom_range(0, 4) == 0), rpc,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
        end

        drain();
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
